// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ID/EX control pipeline stage:
// opcodes, ALU commands, branch types, decode word and stage FSM states.
package ctrl_pkg;

   localparam int unsigned OPC_W  = 6;
   localparam int unsigned ACMD_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP  = 6'd0;
   localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
   localparam logic [OPC_W-1:0] OP_SUB  = 6'd3;
   localparam logic [OPC_W-1:0] OP_AND  = 6'd5;
   localparam logic [OPC_W-1:0] OP_ANDX = 6'd6;
   localparam logic [OPC_W-1:0] OP_OR   = 6'd7;
   localparam logic [OPC_W-1:0] OP_XOR  = 6'd8;
   localparam logic [OPC_W-1:0] OP_SLL  = 6'd9;
   localparam logic [OPC_W-1:0] OP_SLLX = 6'd10;
   localparam logic [OPC_W-1:0] OP_SRL  = 6'd11;
   localparam logic [OPC_W-1:0] OP_SRA  = 6'd12;
   localparam logic [OPC_W-1:0] OP_ADDI = 6'd32;
   localparam logic [OPC_W-1:0] OP_SUBI = 6'd33;
   localparam logic [OPC_W-1:0] OP_LD   = 6'd36;
   localparam logic [OPC_W-1:0] OP_ST   = 6'd37;
   localparam logic [OPC_W-1:0] OP_BEZ  = 6'd40;
   localparam logic [OPC_W-1:0] OP_BNE  = 6'd41;
   localparam logic [OPC_W-1:0] OP_JMP  = 6'd42;

   localparam logic [ACMD_W-1:0] CMD_ADD = 4'b0000;
   localparam logic [ACMD_W-1:0] CMD_SUB = 4'b0010;
   localparam logic [ACMD_W-1:0] CMD_AND = 4'b0100;
   localparam logic [ACMD_W-1:0] CMD_OR  = 4'b0110;
   localparam logic [ACMD_W-1:0] CMD_XOR = 4'b0111;
   localparam logic [ACMD_W-1:0] CMD_SLL = 4'b1000;
   localparam logic [ACMD_W-1:0] CMD_SRL = 4'b1001;
   localparam logic [ACMD_W-1:0] CMD_SRA = 4'b1010;

   typedef enum logic [1:0] {
      BR_JMP = 2'b00,
      BR_BEZ = 2'b01,
      BR_BNE = 2'b10
   } br_type_e;

   typedef struct packed {
      logic [ACMD_W-1:0] cmd;
      logic              mem_read;
      logic              mem_write;
      logic              wb_enable;
      logic              is_imm;
      logic              is_branch;
      br_type_e          br_type;
   } dec_word_t;

   typedef enum logic {
      RUN    = 1'b0,
      SHADOW = 1'b1
   } state_e;

   localparam dec_word_t DEC_NOP = '{cmd: CMD_ADD, mem_read: 1'b0, mem_write: 1'b0,
                                     wb_enable: 1'b0, is_imm: 1'b0, is_branch: 1'b0,
                                     br_type: BR_JMP};

   // Register/immediate ALU op that writes back.
   function automatic dec_word_t alu_word(input logic [ACMD_W-1:0] cmd, input logic imm);
      dec_word_t w;
      w           = DEC_NOP;
      w.cmd       = cmd;
      w.wb_enable = 1'b1;
      w.is_imm    = imm;
      return w;
   endfunction

   function automatic dec_word_t br_word(input br_type_e t);
      dec_word_t w;
      w           = DEC_NOP;
      w.is_branch = 1'b1;
      w.br_type   = t;
      return w;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode table: control word, source-register use and illegal flag.
// Opcodes wider than six bits only match when the upper bits are zero.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W = 6
) (
   input  logic [OP_W-1:0] op_i,
   output dec_word_t       dec_c,
   output logic            use_src1_c,
   output logic            use_src2_c,
   output logic            illegal_c
);

   always_comb begin
      dec_c      = DEC_NOP;
      use_src1_c = 1'b0;
      use_src2_c = 1'b0;
      illegal_c  = 1'b0;
      case (op_i)
         OP_W'(OP_NOP): dec_c = DEC_NOP;
         OP_W'(OP_ADD): begin
            dec_c      = alu_word(CMD_ADD, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_SUB): begin
            dec_c      = alu_word(CMD_SUB, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_AND), OP_W'(OP_ANDX): begin
            dec_c      = alu_word(CMD_AND, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_OR): begin
            dec_c      = alu_word(CMD_OR, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_XOR): begin
            dec_c      = alu_word(CMD_XOR, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_SLL), OP_W'(OP_SLLX): begin
            dec_c      = alu_word(CMD_SLL, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_SRL): begin
            dec_c      = alu_word(CMD_SRL, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_SRA): begin
            dec_c      = alu_word(CMD_SRA, 1'b0);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_ADDI): begin
            dec_c      = alu_word(CMD_ADD, 1'b1);
            use_src1_c = 1'b1;
         end
         OP_W'(OP_SUBI): begin
            dec_c      = alu_word(CMD_SUB, 1'b1);
            use_src1_c = 1'b1;
         end
         OP_W'(OP_LD): begin
            dec_c          = alu_word(CMD_ADD, 1'b0);
            dec_c.mem_read = 1'b1;
            use_src1_c     = 1'b1;
         end
         OP_W'(OP_ST): begin
            dec_c.mem_write = 1'b1;
            use_src1_c      = 1'b1;
            use_src2_c      = 1'b1;
         end
         OP_W'(OP_BEZ): begin
            dec_c      = br_word(BR_BEZ);
            use_src1_c = 1'b1;
         end
         OP_W'(OP_BNE): begin
            dec_c      = br_word(BR_BNE);
            use_src1_c = 1'b1;
            use_src2_c = 1'b1;
         end
         OP_W'(OP_JMP): dec_c = br_word(BR_JMP);
         default:       illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipelined_ctrl_stage.sv
// ID/EX control pipeline register: decodes, holds one control word behind a
// valid/ready handshake, inserts load-use bubbles and discards post-flush shadow.
module pipelined_ctrl_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W         = 6,
   parameter int unsigned CMD_W        = 4,
   parameter int unsigned REG_W        = 5,
   parameter int unsigned SHADOW_DEPTH = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [REG_W-1:0] in_src1,
   input  logic [REG_W-1:0] in_src2,
   input  logic [REG_W-1:0] in_dest,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CMD_W-1:0] out_alu_cmd,
   output logic             out_mem_read,
   output logic             out_mem_write,
   output logic             out_wb_enable,
   output logic             out_is_immediate,
   output logic             out_is_branch,
   output logic [1:0]       out_branch_type,
   output logic [REG_W-1:0] out_src1,
   output logic [REG_W-1:0] out_src2,
   output logic [REG_W-1:0] out_dest,
   output logic             out_illegal,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam int unsigned SH_W = (SHADOW_DEPTH > 0) ? $clog2(SHADOW_DEPTH + 1) : 1;

   dec_word_t  dec_c;
   logic       use_src1_c;
   logic       use_src2_c;
   logic       illegal_c;
   logic       hazard_c;
   logic       accept_c;

   state_e           state_q;
   logic [SH_W-1:0]  shadow_q;
   logic             valid_q;
   dec_word_t        word_q;
   logic             illegal_q;
   logic [REG_W-1:0] src1_q;
   logic [REG_W-1:0] src2_q;
   logic [REG_W-1:0] dest_q;
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] bubble_d;

   ctrl_decode #(.OP_W(OP_W)) u_decode (
      .op_i       (in_op),
      .dec_c      (dec_c),
      .use_src1_c (use_src1_c),
      .use_src2_c (use_src2_c),
      .illegal_c  (illegal_c)
   );

   // Load-use: the held load writes a register the offered instruction reads.
   assign hazard_c = valid_q & word_q.mem_read & (dest_q != '0) & in_valid &
                     ((use_src1_c & (in_src1 == dest_q)) | (use_src2_c & (in_src2 == dest_q)));
   assign in_ready = ~flush & ~hazard_c & (~valid_q | out_ready);
   assign accept_c = in_valid & in_ready;
   assign bubble_d = (bubble_q == '1) ? bubble_q : bubble_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         shadow_q  <= '0;
         valid_q   <= 1'b0;
         word_q    <= DEC_NOP;
         illegal_q <= 1'b0;
         src1_q    <= '0;
         src2_q    <= '0;
         dest_q    <= '0;
         bubble_q  <= '0;
      end else if (flush) begin
         valid_q  <= 1'b0;
         shadow_q <= SH_W'(SHADOW_DEPTH);
         state_q  <= (SHADOW_DEPTH > 0) ? SHADOW : RUN;
      end else if (hazard_c && out_ready) begin
         valid_q  <= 1'b0;
         bubble_q <= bubble_d;
      end else if (accept_c) begin
         if (state_q == RUN) begin
            valid_q   <= 1'b1;
            word_q    <= dec_c;
            illegal_q <= illegal_c;
            src1_q    <= in_src1;
            src2_q    <= in_src2;
            dest_q    <= in_dest;
         end else begin
            // Wrong-path instruction: consume it without loading.
            valid_q  <= 1'b0;
            shadow_q <= shadow_q - SH_W'(1);
            if (shadow_q == SH_W'(1)) begin
               state_q <= RUN;
            end
         end
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid        = valid_q;
   assign out_alu_cmd      = CMD_W'(word_q.cmd);
   assign out_mem_read     = word_q.mem_read;
   assign out_mem_write    = word_q.mem_write;
   assign out_wb_enable    = word_q.wb_enable;
   assign out_is_immediate = word_q.is_imm;
   assign out_is_branch    = word_q.is_branch;
   assign out_branch_type  = word_q.br_type;
   assign out_src1         = src1_q;
   assign out_src2         = src2_q;
   assign out_dest         = dest_q;
   assign out_illegal      = illegal_q;
   assign bubble_cnt       = bubble_q;

endmodule

// File: tb/tb_pipelined_ctrl_stage.sv
// Bench for pipelined_ctrl_stage: table-driven opcode stream checked through a
// scoreboard, plus hazard, flush/shadow, stall and reset sequences.
module tb_pipelined_ctrl_stage;

   localparam int unsigned OP_W = 6;
   localparam int unsigned CMD_W = 4;
   localparam int unsigned REG_W = 5;
   localparam int unsigned SHD = 2;
   localparam int unsigned CNT_W = 16;

   typedef struct {
      logic [5:0] op;
      logic [4:0] s1, s2, d;
      logic [3:0] cmd;
      logic       rd, wr, wb, imm, br;
      logic [1:0] bt;
      logic       ill;
   } rec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, flush, out_valid, out_ready;
   logic [OP_W-1:0]  in_op;
   logic [REG_W-1:0] in_src1, in_src2, in_dest;
   logic [CMD_W-1:0] out_alu_cmd;
   logic             out_mem_read, out_mem_write, out_wb_enable, out_is_immediate;
   logic             out_is_branch, out_illegal;
   logic [1:0]       out_branch_type;
   logic [REG_W-1:0] out_src1, out_src2, out_dest;
   logic [CNT_W-1:0] bubble_cnt;

   int   n_checks = 0;
   int   n_errors = 0;
   rec_t cur;
   rec_t sb[$];
   int   sh = 0;
   rec_t vec[20];

   pipelined_ctrl_stage #(.OP_W(OP_W), .CMD_W(CMD_W), .REG_W(REG_W),
                          .SHADOW_DEPTH(SHD), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_cmd(out_alu_cmd), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_wb_enable(out_wb_enable), .out_is_immediate(out_is_immediate),
      .out_is_branch(out_is_branch), .out_branch_type(out_branch_type),
      .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
      .out_illegal(out_illegal), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic rec_t mkr(input int op, input int s1, input int s2, input int d,
                                input int cmd, input bit rd, input bit wr, input bit wb,
                                input bit imm, input bit br, input int bt, input bit ill);
      rec_t r;
      r.op = 6'(op); r.s1 = 5'(s1); r.s2 = 5'(s2); r.d = 5'(d); r.cmd = 4'(cmd);
      r.rd = rd; r.wr = wr; r.wb = wb; r.imm = imm; r.br = br; r.bt = 2'(bt); r.ill = ill;
      return r;
   endfunction

   // Scoreboard: words accepted outside the shadow window must emerge in order.
   always @(negedge clk) begin
      rec_t e;
      if (rst_n) begin
         if (flush) begin
            sb.delete();
            sh = SHD;
         end else begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 32'(out_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("alu_cmd",   32'(out_alu_cmd),      32'(e.cmd));
                  chk("mem_read",  32'(out_mem_read),     32'(e.rd));
                  chk("mem_write", 32'(out_mem_write),    32'(e.wr));
                  chk("wb_enable", 32'(out_wb_enable),    32'(e.wb));
                  chk("is_imm",    32'(out_is_immediate), 32'(e.imm));
                  chk("is_branch", 32'(out_is_branch),    32'(e.br));
                  chk("br_type",   32'(out_branch_type),  32'(e.bt));
                  chk("illegal",   32'(out_illegal),      32'(e.ill));
                  chk("src1",      32'(out_src1),         32'(e.s1));
                  chk("src2",      32'(out_src2),         32'(e.s2));
                  chk("dest",      32'(out_dest),         32'(e.d));
               end
            end
            if (in_valid && in_ready) begin
               if (sh > 0) sh--;
               else sb.push_back(cur);
            end
         end
      end
   end

   task automatic drive(input rec_t r);
      cur      = r;
      in_valid = 1'b1;
      in_op    = OP_W'(r.op);
      in_src1  = r.s1;
      in_src2  = r.s2;
      in_dest  = r.d;
   endtask

   // Offer r until accepted; waits = cycles spent stalled before acceptance.
   task automatic send(input rec_t r, output int waits);
      bit acc = 1'b0;
      drive(r);
      waits = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (!acc) waits++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int w;
      rec_t ld3, add3, ld0, add0, jmp3, bez3;
      vec[0]  = mkr( 1, 1, 2,  4, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
      vec[1]  = mkr(32, 1, 2,  5, 4'b0000, 0, 0, 1, 1, 0, 0, 0);
      vec[2]  = mkr(36, 1, 2,  6, 4'b0000, 1, 0, 1, 0, 0, 0, 0);
      vec[3]  = mkr(37, 1, 2,  7, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
      vec[4]  = mkr(40, 1, 2,  8, 4'b0000, 0, 0, 0, 0, 1, 1, 0);
      vec[5]  = mkr( 3, 1, 2,  9, 4'b0010, 0, 0, 1, 0, 0, 0, 0);
      vec[6]  = mkr( 5, 1, 2, 10, 4'b0100, 0, 0, 1, 0, 0, 0, 0);
      vec[7]  = mkr( 6, 1, 2, 11, 4'b0100, 0, 0, 1, 0, 0, 0, 0);
      vec[8]  = mkr( 7, 1, 2, 12, 4'b0110, 0, 0, 1, 0, 0, 0, 0);
      vec[9]  = mkr( 8, 1, 2, 13, 4'b0111, 0, 0, 1, 0, 0, 0, 0);
      vec[10] = mkr( 9, 1, 2, 14, 4'b1000, 0, 0, 1, 0, 0, 0, 0);
      vec[11] = mkr(10, 1, 2, 15, 4'b1000, 0, 0, 1, 0, 0, 0, 0);
      vec[12] = mkr(11, 1, 2, 16, 4'b1001, 0, 0, 1, 0, 0, 0, 0);
      vec[13] = mkr(12, 1, 2, 17, 4'b1010, 0, 0, 1, 0, 0, 0, 0);
      vec[14] = mkr(33, 1, 2, 18, 4'b0010, 0, 0, 1, 1, 0, 0, 0);
      vec[15] = mkr(41, 1, 2, 19, 4'b0000, 0, 0, 0, 0, 1, 2, 0);
      vec[16] = mkr(42, 1, 2, 20, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
      vec[17] = mkr( 0, 1, 2, 21, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
      vec[18] = mkr( 2, 1, 2, 22, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
      vec[19] = mkr(63, 1, 2, 23, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
      ld3  = mkr(36, 1, 2, 3, 4'b0000, 1, 0, 1, 0, 0, 0, 0);
      add3 = mkr( 1, 3, 2, 4, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
      ld0  = mkr(36, 1, 2, 0, 4'b0000, 1, 0, 1, 0, 0, 0, 0);
      add0 = mkr( 1, 0, 0, 5, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
      jmp3 = mkr(42, 3, 3, 0, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
      bez3 = mkr(40, 1, 3, 0, 4'b0000, 0, 0, 0, 0, 1, 1, 0);

      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
      in_dest = '0; flush = 1'b0; out_ready = 1'b1; cur = vec[0];
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_alu_cmd",   32'(out_alu_cmd), 32'd0);
      chk("rst_wb",        32'(out_wb_enable), 32'd0);
      chk("rst_dest",      32'(out_dest), 32'd0);
      chk("rst_bubble",    32'(bubble_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Full-rate stream through the whole opcode table.
      for (int i = 0; i < 20; i++) begin
         send(vec[i], w);
         chk("stream_waits", 32'(w), 32'd0);
         chk("stream_valid", 32'(out_valid), 32'd1);
      end
      idle(2);

      // Load-use hazard: one bubble, then the dependent ADD.
      send(ld3, w);
      send(add3, w);
      chk("hazard_bubble_cycles", 32'(w), 32'd1);
      chk("hazard_bubble_cnt", 32'(bubble_cnt), 32'd1);
      chk("hazard_add_valid", 32'(out_valid), 32'd1);
      chk("hazard_add_src1", 32'(out_src1), 32'd3);

      // No hazard: dest 0, or consumer that does not read the register.
      send(ld0, w);
      send(add0, w);
      chk("ld_r0_waits", 32'(w), 32'd0);
      send(ld3, w);
      send(jmp3, w);
      chk("ld_jmp_waits", 32'(w), 32'd0);
      send(ld3, w);
      send(bez3, w);
      chk("ld_bez_src2_waits", 32'(w), 32'd0);
      chk("no_hazard_bubble_cnt", 32'(bubble_cnt), 32'd1);
      idle(2);

      // Flush with ADD held and SUB offered; two accepts are then discarded.
      out_ready = 1'b0;
      send(vec[0], w);
      drive(vec[5]);
      flush = 1'b1;
      #3;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      send(vec[5], w);
      chk("shadow1_valid", 32'(out_valid), 32'd0);
      send(vec[6], w);
      chk("shadow2_valid", 32'(out_valid), 32'd0);
      send(vec[8], w);
      chk("post_shadow_valid", 32'(out_valid), 32'd1);
      chk("post_shadow_cmd", 32'(out_alu_cmd), 32'(vec[8].cmd));
      send(vec[9], w);
      chk("run_again_valid", 32'(out_valid), 32'd1);
      idle(2);

      // Back-pressure: word held stable for three cycles, then consumed.
      out_ready = 1'b0;
      send(vec[13], w);
      drive(vec[10]);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_cmd", 32'(out_alu_cmd), 32'(vec[13].cmd));
         chk("stall_dest", 32'(out_dest), 32'(vec[13].d));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(vec[10], w);
      chk("release_waits", 32'(w), 32'd0);
      chk("release_next_cmd", 32'(out_alu_cmd), 32'(vec[10].cmd));
      idle(3);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      // Asynchronous reset in the middle of a cycle drops the held word.
      out_ready = 1'b0;
      send(vec[1], w);
      #3;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_bubble", 32'(bubble_cnt), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(2);
      chk("after_rst_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipelined_ctrl_stage.md
Name: pipelined_ctrl_stage

Overview:
Parametrised, registered successor to the combinational opcode decoder; it sits between IF/ID and EX as the ID/EX control pipeline register. It decodes each instruction to ALU command, memory, write-back, immediate and branch controls, then holds the result in a single-entry pipeline register with valid/ready handshakes. It inserts a bubble on load-use hazards and discards wrong-path instructions after an EX flush. It flags illegal opcodes and keeps a saturating bubble counter.

Parameters:
OP_W, 6, opcode width (must be ≥6; opcodes compared zero-extended)
CMD_W, 4, ALU command width (must be ≥4; commands zero-extended)
REG_W, 5, register index width
SHADOW_DEPTH, 1, accepted instructions discarded after a flush (0 = none)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID offers instruction
in_ready  out  1  stage accepts (combinational)
in_op  in  OP_W  opcode
in_src1  in  REG_W  source reg 1
in_src2  in  REG_W  source reg 2
in_dest  in  REG_W  destination reg
flush  in  1  EX branch taken; kill held and wrong-path instructions
out_valid  out  1  registered control word valid
out_ready  in  1  EX consumes
out_alu_cmd  out  CMD_W  ALU command
out_mem_read  out  1  load
out_mem_write  out  1  store
out_wb_enable  out  1  register write-back
out_is_immediate  out  1  second operand is immediate
out_is_branch  out  1  instruction is branch/jump
out_branch_type  out  2  00 JMP, 01 BEZ, 10 BNE
out_src1, out_src2, out_dest  out  REG_W  registered register indices
out_illegal  out  1  opcode not in table
bubble_cnt  out  CNT_W  saturating count of inserted hazard bubbles

Behaviour:
- Reset: clk and rst_n are fixed as above; all out_* and bubble_cnt are 0, FSM is RUN, shadow counter is 0. Reset mid-operation drops the held instruction immediately.
- Decode table (opcode: cmd, flags):
- 0 NOP: cmd 0, no flags.
- 1: cmd 0000, wb. 3: cmd 0010, wb. 5 and 6: cmd 0100, wb. 7: cmd 0110, wb. 8: cmd 0111, wb. 9 and 10: cmd 1000, wb. 11: cmd 1001, wb. 12: cmd 1010, wb.
- 32: cmd 0000, wb, imm. 33: cmd 0010, wb, imm. 36 LD: cmd 0000, mem_read, wb. 37 ST: cmd 0000, mem_write.
- 40: branch, type 01. 41: branch, type 10. 42: branch, type 00.
- Any other opcode: NOP controls, illegal=1. The table never emits X; branches and NOP use cmd 0.
- Source use: src1 is used by all table opcodes except 0 and 42. src2 is used by 1–12, 37 and 41.
- Hazard (combinational): out_valid & out_mem_read & out_dest≠0 & in_valid & (src1 used & in_src1==out_dest | src2 used & in_src2==out_dest).
- in_ready = ¬flush & ¬hazard & (¬out_valid | out_ready).
- Register update, priority order:
- 1) flush: out_valid←0. In that cycle the offered instruction is not accepted. Shadow counter←SHADOW_DEPTH; state←SHADOW if SHADOW_DEPTH>0. Flush while in SHADOW reloads the counter.
- 2) hazard & out_ready: the load leaves and a bubble loads (out_valid←0). bubble_cnt increments and saturates at all-ones. The instruction is accepted next cycle, giving 1 bubble latency.
- 3) accept (in_valid & in_ready): in RUN, the decoded word loads with out_valid←1. In SHADOW, the word is discarded and out_valid←0. The counter decrements; at 1→0 the state goes to RUN, so the next accepted instruction loads.
- 4) out_ready & out_valid with no accept: out_valid←0.
- 5) otherwise hold; out_* stay stable while out_valid & ¬out_ready.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 per cycle with no hazards.
- Hazard with ¬out_ready: hold, no bubble counted.

Decomposition:
- Shared package ctrl_pkg holds:
- opcode localparams (OP_NOP … OP_JMP)
- ALU command constants
- branch type enum (BR_JMP, BR_BEZ, BR_BNE)
- a decode-word struct
- FSM state enum (RUN, SHADOW)
- Sub-module ctrl_decode is the purely combinational table giving decode word, src-use bits and illegal. This stage instantiates it once.

Test Plan:
- Reset, then stream opcodes 1,32,36,37,40 with out_ready=1 -> one cycle later each: cmd 0000/wb, imm, mem_read+wb, mem_write, branch type 01; out_valid continuous.
- LD dest=3, then ADD src1=3 -> exactly one out_valid=0 cycle between them; bubble_cnt=1; ADD emerges the cycle after.
- LD dest=0, then ADD src1=0; also LD dest=3, then JMP -> no bubble, bubble_cnt unchanged.
- SHADOW_DEPTH=2: flush with ADD held and SUB offered -> out_valid=0. The next two accepted instructions are discarded; the third appears on out_*; state returns to RUN.
- out_ready=0 for 3 cycles with a valid word -> in_ready=0, out_* stable; release -> word consumed, next loads.
- Opcode 2 and 63 -> out_illegal=1, wb=0, mem_read=0, mem_write=0; async rst_n low mid-stream -> out_valid=0 immediately.
